clock_ratio_meter: RTL and testbench
====================================

CLOCK_RATIO_METER -- requirements
Module: clock_ratio_meter

Interface
REQ-001 Parameter: WIDTH, 30, width of interval counter and measurement outputs.
REQ-002 Parameter: LOCK_COUNT, 4, consecutive equal measurements required for lock (min 2).
REQ-003 Parameter: TIMEOUT_CYCLES, 1024, clock cycles without a div_in edge before timeout (min 4).
REQ-004 clock  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 div_in  input  1  divided-clock signal under measurement, asynchronous to clock.
REQ-007 half_period  output  WIDTH  last measured phase length in clock cycles.
REQ-008 meas_valid  output  1  one-cycle pulse, new half_period published.
REQ-009 meas_level  output  1  level of the measured phase (1 = high phase, 0 = low phase).
REQ-010 est_limit  output  WIDTH  half_period - 1, or 0 when half_period is 0; recovered divider limit.
REQ-011 locked  output  1  LOCK_COUNT consecutive equal measurements seen.
REQ-012 lock_lost  output  1  one-cycle pulse on LOCKED exit.
REQ-013 timeout  output  1  level, no edge within TIMEOUT_CYCLES.

Function
REQ-014 div_in SHALL pass through a 2-flop synchroniser (s1, s2), then a third flop s3; edge = s2 XOR s3.
REQ-015 meas_valid SHALL assert on the 3rd rising clock edge after the edge that first samples the new div_in level.
REQ-016 Interval counter SHALL increment every cycle, clear to 0 on a detected edge, and saturate at 2^WIDTH-1.
REQ-017 On a detected edge in ARMED or LOCKED, half_period SHALL load counter+1 (saturating), meas_level SHALL load s3, meas_valid SHALL pulse.
REQ-018 A div_in toggling every N clock cycles SHALL yield half_period = N and est_limit = N-1.
REQ-019 States: IDLE, ARMED, LOCKED, TIMEOUT; encoded in package enum.
REQ-020 IDLE: first edge -> ARMED, counter cleared, no publish, run = 0.
REQ-021 ARMED: each published measurement updates run: equal to previous half_period -> run+1 (saturate LOCK_COUNT); else run = 1; first measurement after IDLE/TIMEOUT -> run = 1.
REQ-022 ARMED -> LOCKED in the same cycle run reaches LOCK_COUNT; locked asserts with that meas_valid.
REQ-023 LOCKED: unequal measurement -> ARMED, run = 1, locked deasserts and lock_lost pulses with that meas_valid.
REQ-024 Measurement comparison SHALL ignore meas_level; asymmetric duty breaks lock.
REQ-025 ARMED/LOCKED: counter reaching TIMEOUT_CYCLES-1 with no edge -> TIMEOUT next cycle; timeout = 1, locked = 0, run = 0; lock_lost pulses if leaving LOCKED.
REQ-026 IDLE also times out by the same rule.
REQ-027 TIMEOUT: next edge -> ARMED as in IDLE (no publish); timeout clears same cycle.
REQ-028 Edge and timeout threshold in same cycle: edge wins, no timeout.
REQ-029 half_period and meas_level SHALL hold between measurements, including through TIMEOUT.

Reset
REQ-030 reset SHALL clear s1-s3, counter, run, half_period, meas_level, meas_valid, locked, lock_lost, timeout to 0 and state to IDLE; est_limit reads 0.
REQ-031 Reset mid-measurement SHALL discard the partial interval; div_in high at release yields one edge treated as IDLE first edge.

Structure
REQ-032 Package clock_ratio_meter_pkg SHALL hold the state enum and default WIDTH constant.
REQ-033 Sub-module sync_edge_detect SHALL contain s1-s3 and produce edge and level.

Verification
REQ-034 div_in toggles every 10 cycles from reset -> half_period = 10, est_limit = 9, locked on 4th meas_valid.
REQ-035 Locked at 10, then one phase of 12 -> lock_lost pulse, locked = 0, half_period = 12; lock regained after 4 equal measurements.
REQ-036 div_in held static after lock -> timeout = 1 exactly 1024 cycles after last edge, locked = 0, half_period stays 10.
REQ-037 Duty 7 high / 13 low -> meas_level alternates, half_period alternates 7/13, locked never asserts.
REQ-038 reset asserted mid-phase while locked -> all outputs 0 next cycle; resumed 10-cycle toggling relocks after 4 measurements.
REQ-039 Edge arriving on the cycle counter reaches 1023 -> measurement published (half_period = 1024), no timeout.

Source files
------------

// File: rtl/clock_ratio_meter_pkg.sv
// Shared types and defaults for the clock ratio meter.
package clock_ratio_meter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 30;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

endpackage

// File: rtl/clock_ratio_meter_sync_edge_detect.sv
// Two-flop synchroniser plus a history flop; emits a registered edge strobe
// and the level of the phase that just ended.
module sync_edge_detect
    import clock_ratio_meter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_edge,
    output logic o_level
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_edge;
    logic r_level;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_edge  <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_s1    <= i_async;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_edge  <= r_s2 ^ r_s3;
            r_level <= r_s3;
        end
    end

    assign o_edge  = r_edge;
    assign o_level = r_level;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures the phase length of a divided clock, recovers the divider limit,
// and tracks lock / timeout of that measurement.
module clock_ratio_meter
    import clock_ratio_meter_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_div_in,
    output logic [WIDTH-1:0] o_half_period,
    output logic             o_meas_valid,
    output logic             o_meas_level,
    output logic [WIDTH-1:0] o_est_limit,
    output logic             o_locked,
    output logic             o_lock_lost,
    output logic             o_timeout
);

    localparam int unsigned      RUN_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] TO_LAST  = WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [RUN_W-1:0] LOCK_VAL = RUN_W'(LOCK_COUNT);

    logic w_edge;
    logic w_level;

    sync_edge_detect u_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (i_div_in),
        .o_edge  (w_edge),
        .o_level (w_level)
    );

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [RUN_W-1:0] r_run;
    logic [WIDTH-1:0] r_half_period;
    logic             r_meas_valid;
    logic             r_meas_level;
    logic [WIDTH-1:0] r_est_limit;
    logic             r_locked;
    logic             r_lock_lost;
    logic             r_timeout;

    state_t           w_state_n;
    logic [WIDTH-1:0] w_cnt_n;
    logic [RUN_W-1:0] w_run_n;
    logic [WIDTH-1:0] w_hp_n;
    logic             w_valid_n;
    logic             w_level_n;
    logic [WIDTH-1:0] w_est_n;
    logic             w_lost_n;
    logic [WIDTH-1:0] w_meas;
    logic             w_same;
    logic [RUN_W-1:0] w_run_inc;
    logic             w_to_hit;

    // Saturating count+1 doubles as the measured length when an edge lands.
    assign w_meas    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + WIDTH'(1);
    assign w_same    = (w_meas == r_half_period);
    assign w_run_inc = (r_run >= LOCK_VAL) ? LOCK_VAL : r_run + RUN_W'(1);
    assign w_to_hit  = (r_cnt == TO_LAST);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_meas;
        w_run_n   = r_run;
        w_hp_n    = r_half_period;
        w_valid_n = 1'b0;
        w_level_n = r_meas_level;
        w_lost_n  = 1'b0;

        case (r_state)
            ST_IDLE, ST_TIMEOUT: begin
                if (w_edge) begin
                    w_state_n = ST_ARMED;
                    w_cnt_n   = '0;
                    w_run_n   = '0;
                end else if (r_state == ST_IDLE && w_to_hit) begin
                    w_state_n = ST_TIMEOUT;
                    w_run_n   = '0;
                end
            end
            ST_ARMED: begin
                if (w_edge) begin
                    w_cnt_n   = '0;
                    w_hp_n    = w_meas;
                    w_level_n = w_level;
                    w_valid_n = 1'b1;
                    // run==0 marks the first measurement since arming
                    w_run_n   = (r_run != '0 && w_same) ? w_run_inc : RUN_W'(1);
                    if (w_run_n == LOCK_VAL) begin
                        w_state_n = ST_LOCKED;
                    end
                end else if (w_to_hit) begin
                    w_state_n = ST_TIMEOUT;
                    w_run_n   = '0;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    w_cnt_n   = '0;
                    w_hp_n    = w_meas;
                    w_level_n = w_level;
                    w_valid_n = 1'b1;
                    if (!w_same) begin
                        w_state_n = ST_ARMED;
                        w_run_n   = RUN_W'(1);
                        w_lost_n  = 1'b1;
                    end
                end else if (w_to_hit) begin
                    w_state_n = ST_TIMEOUT;
                    w_run_n   = '0;
                    w_lost_n  = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        w_est_n = (w_hp_n == '0) ? '0 : w_hp_n - WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_run         <= '0;
            r_half_period <= '0;
            r_meas_valid  <= 1'b0;
            r_meas_level  <= 1'b0;
            r_est_limit   <= '0;
            r_locked      <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_run         <= w_run_n;
            r_half_period <= w_hp_n;
            r_meas_valid  <= w_valid_n;
            r_meas_level  <= w_level_n;
            r_est_limit   <= w_est_n;
            r_locked      <= (w_state_n == ST_LOCKED);
            r_lock_lost   <= w_lost_n;
            r_timeout     <= (w_state_n == ST_TIMEOUT);
        end
    end

    assign o_half_period = r_half_period;
    assign o_meas_valid  = r_meas_valid;
    assign o_meas_level  = r_meas_level;
    assign o_est_limit   = r_est_limit;
    assign o_locked      = r_locked;
    assign o_lock_lost   = r_lock_lost;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter: lock, lock loss, timeout, duty, reset, boundary.
module tb_clock_ratio_meter;

    localparam int unsigned WIDTH = 30;

    logic             clock;
    logic             reset;
    logic             i_div_in;
    logic [WIDTH-1:0] o_half_period;
    logic             o_meas_valid;
    logic             o_meas_level;
    logic [WIDTH-1:0] o_est_limit;
    logic             o_locked;
    logic             o_lock_lost;
    logic             o_timeout;

    int total = 0;
    int bad   = 0;

    // Per-phase capture, filled by drive_phase
    int               n_valid;
    int               n_lost;
    int               cap_k;
    logic             any_locked;
    logic             any_timeout;
    logic [WIDTH-1:0] cap_hp;
    logic [WIDTH-1:0] cap_est;
    logic             cap_lvl;
    logic             cap_locked;

    clock_ratio_meter #(
        .WIDTH          (WIDTH),
        .LOCK_COUNT     (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_div_in      (i_div_in),
        .o_half_period (o_half_period),
        .o_meas_valid  (o_meas_valid),
        .o_meas_level  (o_meas_level),
        .o_est_limit   (o_est_limit),
        .o_locked      (o_locked),
        .o_lock_lost   (o_lock_lost),
        .o_timeout     (o_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hold div_in at lvl for n cycles, sampling 1 time unit after each rising edge.
    task automatic drive_phase(input logic lvl, input int n);
        i_div_in    = lvl;
        n_valid     = 0;
        n_lost      = 0;
        cap_k       = -1;
        any_locked  = 1'b0;
        any_timeout = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (o_meas_valid) begin
                n_valid++;
                cap_k      = k;
                cap_hp     = o_half_period;
                cap_est    = o_est_limit;
                cap_lvl    = o_meas_level;
                cap_locked = o_locked;
            end
            if (o_lock_lost) n_lost++;
            if (o_locked)    any_locked  = 1'b1;
            if (o_timeout)   any_timeout = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        i_div_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (o_half_period !== '0) begin bad++; $display("FAIL reset_hp got=%0d exp=0", o_half_period); end
        total++; if (o_meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_meas_valid); end
        total++; if (o_meas_level !== 1'b0) begin bad++; $display("FAIL reset_level got=%b exp=0", o_meas_level); end
        total++; if (o_est_limit !== '0) begin bad++; $display("FAIL reset_est got=%0d exp=0", o_est_limit); end
        total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", o_locked); end
        total++; if (o_lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b exp=0", o_lock_lost); end
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", o_timeout); end
        reset = 1'b0;
    endtask

    // 10-cycle toggling: first edge only arms, 4th measurement locks.
    task automatic test_lock;
        logic lvl;
        drive_phase(1'b1, 10);
        total++; if (n_valid !== 0) begin bad++; $display("FAIL lock_first_edge valid_count got=%0d exp=0", n_valid); end
        lvl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_phase(lvl, 10);
            total++; if (n_valid !== 1) begin bad++; $display("FAIL lock_valid_count[%0d] got=%0d exp=1", i, n_valid); end
            total++; if (cap_hp !== WIDTH'(10)) begin bad++; $display("FAIL lock_hp[%0d] got=%0d exp=10", i, cap_hp); end
            total++; if (cap_est !== WIDTH'(9)) begin bad++; $display("FAIL lock_est[%0d] got=%0d exp=9", i, cap_est); end
            total++; if (cap_lvl !== ~lvl) begin bad++; $display("FAIL lock_level[%0d] got=%b exp=%b", i, cap_lvl, ~lvl); end
            total++; if (cap_locked !== (i == 3)) begin bad++; $display("FAIL lock_locked[%0d] got=%b exp=%b", i, cap_locked, (i == 3)); end
            if (i == 0) begin
                total++; if (cap_k !== 3) begin bad++; $display("FAIL valid_latency got=%0d exp=3", cap_k); end
            end
            lvl = ~lvl;
        end
    endtask

    // One 12-cycle phase breaks lock; four 10-cycle measurements regain it.
    task automatic test_lock_loss;
        logic lvl;
        drive_phase(1'b0, 12);
        total++; if (cap_locked !== 1'b1 || cap_hp !== WIDTH'(10)) begin bad++; $display("FAIL loss_pre got_locked=%b got_hp=%0d exp=1/10", cap_locked, cap_hp); end
        drive_phase(1'b1, 10);
        total++; if (cap_hp !== WIDTH'(12)) begin bad++; $display("FAIL loss_hp got=%0d exp=12", cap_hp); end
        total++; if (n_lost !== 1) begin bad++; $display("FAIL loss_pulse got=%0d exp=1", n_lost); end
        total++; if (cap_locked !== 1'b0) begin bad++; $display("FAIL loss_locked got=%b exp=0", cap_locked); end
        lvl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_phase(lvl, 10);
            total++; if (cap_hp !== WIDTH'(10)) begin bad++; $display("FAIL relock_hp[%0d] got=%0d exp=10", i, cap_hp); end
            total++; if (cap_locked !== (i == 3)) begin bad++; $display("FAIL relock_locked[%0d] got=%b exp=%b", i, cap_locked, (i == 3)); end
            lvl = ~lvl;
        end
    endtask

    // Static div_in after lock: timeout 1024 cycles after the last published edge.
    task automatic test_timeout;
        int valid_k = -1;
        int to_k    = -1;
        logic to_locked = 1'b1;
        logic to_lost   = 1'b0;
        i_div_in = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            @(posedge clock);
            #1;
            if (o_meas_valid && valid_k < 0) valid_k = k;
            if (o_timeout && to_k < 0) begin
                to_k      = k;
                to_locked = o_locked;
                to_lost   = o_lock_lost;
            end
        end
        total++; if (valid_k !== 3) begin bad++; $display("FAIL to_last_valid got=%0d exp=3", valid_k); end
        total++; if (to_k !== 1027) begin bad++; $display("FAIL to_cycle got=%0d exp=1027", to_k); end
        total++; if (to_locked !== 1'b0) begin bad++; $display("FAIL to_locked got=%b exp=0", to_locked); end
        total++; if (to_lost !== 1'b1) begin bad++; $display("FAIL to_lost got=%b exp=1", to_lost); end
        total++; if (o_half_period !== WIDTH'(10)) begin bad++; $display("FAIL to_hp_hold got=%0d exp=10", o_half_period); end
    endtask

    // 7 high / 13 low from TIMEOUT: alternating measurements, never locked.
    task automatic test_duty;
        logic saw_lock = 1'b0;
        drive_phase(1'b1, 7);
        total++; if (n_valid !== 0) begin bad++; $display("FAIL duty_arm valid_count got=%0d exp=0", n_valid); end
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL duty_to_clear got=%b exp=0", o_timeout); end
        for (int i = 0; i < 3; i++) begin
            drive_phase(1'b0, 13);
            if (any_locked) saw_lock = 1'b1;
            total++; if (cap_hp !== WIDTH'(7) || cap_lvl !== 1'b1 || cap_est !== WIDTH'(6)) begin bad++; $display("FAIL duty_high[%0d] got_hp=%0d got_lvl=%b got_est=%0d exp=7/1/6", i, cap_hp, cap_lvl, cap_est); end
            drive_phase(1'b1, 7);
            if (any_locked) saw_lock = 1'b1;
            total++; if (cap_hp !== WIDTH'(13) || cap_lvl !== 1'b0 || cap_est !== WIDTH'(12)) begin bad++; $display("FAIL duty_low[%0d] got_hp=%0d got_lvl=%b got_est=%0d exp=13/0/12", i, cap_hp, cap_lvl, cap_est); end
        end
        total++; if (saw_lock !== 1'b0) begin bad++; $display("FAIL duty_never_locked got=%b exp=0", saw_lock); end
    endtask

    // Reset mid-phase while locked, then relock with div_in high at release.
    task automatic test_reset_mid;
        logic lvl;
        lvl = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_phase(lvl, 10);
            lvl = ~lvl;
        end
        total++; if (cap_locked !== 1'b1) begin bad++; $display("FAIL rmid_prelock got=%b exp=1", cap_locked); end
        drive_phase(1'b1, 5);
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++; if (o_half_period !== '0 || o_est_limit !== '0) begin bad++; $display("FAIL rmid_hp_est got_hp=%0d got_est=%0d exp=0/0", o_half_period, o_est_limit); end
        total++; if ({o_meas_valid, o_meas_level, o_locked, o_lock_lost, o_timeout} !== 5'b0) begin bad++; $display("FAIL rmid_flags got=%b exp=00000", {o_meas_valid, o_meas_level, o_locked, o_lock_lost, o_timeout}); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive_phase(1'b1, 10);
        total++; if (n_valid !== 0) begin bad++; $display("FAIL rmid_arm valid_count got=%0d exp=0", n_valid); end
        lvl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_phase(lvl, 10);
            total++; if (cap_hp !== WIDTH'(10) || cap_locked !== (i == 3)) begin bad++; $display("FAIL rmid_relock[%0d] got_hp=%0d got_locked=%b exp=10/%b", i, cap_hp, cap_locked, (i == 3)); end
            lvl = ~lvl;
        end
    endtask

    // 1024-cycle phase is measured without timeout; 1025 times out first.
    task automatic test_boundary;
        logic saw_to = 1'b0;
        drive_phase(1'b0, 1024);
        if (any_timeout) saw_to = 1'b1;
        drive_phase(1'b1, 10);
        if (any_timeout) saw_to = 1'b1;
        total++; if (n_valid !== 1 || cap_hp !== WIDTH'(1024)) begin bad++; $display("FAIL bnd_1024_hp got_n=%0d got_hp=%0d exp=1/1024", n_valid, cap_hp); end
        total++; if (cap_est !== WIDTH'(1023)) begin bad++; $display("FAIL bnd_1024_est got=%0d exp=1023", cap_est); end
        total++; if (saw_to !== 1'b0) begin bad++; $display("FAIL bnd_1024_no_timeout got=%b exp=0", saw_to); end
        total++; if (n_lost !== 1 || cap_locked !== 1'b0) begin bad++; $display("FAIL bnd_1024_lost got_n=%0d got_locked=%b exp=1/0", n_lost, cap_locked); end
        drive_phase(1'b0, 1025);
        total++; if (n_valid !== 1 || cap_hp !== WIDTH'(10)) begin bad++; $display("FAIL bnd_1025_pre got_n=%0d got_hp=%0d exp=1/10", n_valid, cap_hp); end
        drive_phase(1'b1, 10);
        total++; if (any_timeout !== 1'b1) begin bad++; $display("FAIL bnd_1025_timeout got=%b exp=1", any_timeout); end
        total++; if (n_valid !== 0) begin bad++; $display("FAIL bnd_1025_no_publish got=%0d exp=0", n_valid); end
        total++; if (o_timeout !== 1'b0 || o_half_period !== WIDTH'(10)) begin bad++; $display("FAIL bnd_1025_after got_to=%b got_hp=%0d exp=0/10", o_timeout, o_half_period); end
    endtask

    initial begin
        reset    = 1'b1;
        i_div_in = 1'b0;
        test_reset;
        test_lock;
        test_lock_loss;
        test_timeout;
        test_duty;
        test_reset_mid;
        test_boundary;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
